// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared AXI4-Lite definitions for the slave memory endpoint: bus widths,
// response codes, channel FSM states and address decode helper.
package axi4_lite_slave_mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Extra top bit on span/offset so a window ending at 2**ADDR_W still decodes.
   function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W:0]   span);
      logic [ADDR_W:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return (addr >= base) && (off < span);
   endfunction

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite five-channel bundle between the bus master and the memory slave.
interface axi4_lite_slave_mem_if;
   import axi4_lite_slave_mem_pkg::*;

   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axi4_lite_slave_mem_mem_array.sv
// Word-organised RAM: one byte-enable write port and one registered read port.
// A read and a write to the same word on one edge returns the old word.
module axi4_lite_mem_array #(
   parameter  int Mem_Depth  = 1024,
   parameter  int Data_Width = 32,
   localparam int IDX_W      = $clog2(Mem_Depth)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [Data_Width-1:0]   wr_data,
   input  logic [Data_Width/8-1:0] wr_strb,
   input  logic                    rd_en,
   input  logic                    rd_hit,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [Data_Width-1:0]   rd_data
);

   logic [Data_Width-1:0] mem [Mem_Depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < Data_Width/8; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Out-of-range reads load zero so the bus never sees stale data.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_hit ? mem[rd_idx] : '0;
   end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave terminating all five channels into a byte-strobed word memory.
//   state  | meaning
//   W_IDLE | collecting AW and W (either order); commit when both are in hand
//   W_RESP | BVALID/BRESP held until BREADY
//   R_IDLE | ARREADY high, waiting for an address
//   R_DATA | RVALID/RDATA/RRESP held until RREADY
module axi4_lite_slave_mem
   import axi4_lite_slave_mem_pkg::*;
#(
   parameter int                Addr_Width = ADDR_W,
   parameter int                Data_Width = DATA_W,
   parameter int                Mem_Depth  = 1024,
   parameter logic [ADDR_W-1:0] Base_Addr  = 32'h0000_0000
) (
   input logic                  ACLK,
   input logic                  ARESET,
   axi4_lite_slave_mem_if.slave bus
);

   localparam int IDX_W = $clog2(Mem_Depth);
   localparam logic [Addr_Width:0] SPAN = (Addr_Width+1)'(4 * Mem_Depth);

   wr_state_t wr_state;
   rd_state_t rd_state;

   logic                    aw_done, w_done;
   logic [Addr_Width-1:0]   aw_addr_q;
   logic [Data_Width-1:0]   w_data_q;
   logic [Data_Width/8-1:0] w_strb_q;

   logic                    aw_fire, w_fire, commit, ar_fire;
   logic [Addr_Width-1:0]   wr_addr, wr_off, rd_off;
   logic [Data_Width-1:0]   wr_data;
   logic [Data_Width/8-1:0] wr_strb;
   logic                    wr_hit, rd_hit;
   logic                    unused_bits;

   // Commit uses the live bus value for whichever half handshakes this edge.
   always_comb begin
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      commit  = !ARESET && (wr_state == W_IDLE) && (aw_done || aw_fire) && (w_done || w_fire);
      wr_addr = aw_done ? aw_addr_q : bus.AWADDR;
      wr_data = w_done ? w_data_q : bus.WDATA;
      wr_strb = w_done ? w_strb_q : bus.WSTRB;
      wr_hit  = addr_hit(wr_addr, Base_Addr, SPAN);
      wr_off  = wr_addr - Base_Addr;
      ar_fire = !ARESET && bus.ARVALID && bus.ARREADY;
      rd_hit  = addr_hit(bus.ARADDR, Base_Addr, SPAN);
      rd_off  = bus.ARADDR - Base_Addr;
   end

   assign unused_bits = ^{bus.AWPROT, bus.ARPROT, wr_off, rd_off};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state    <= W_IDLE;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         bus.AWREADY <= 1'b0;
         bus.WREADY  <= 1'b0;
         bus.BVALID  <= 1'b0;
         bus.BRESP   <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_fire) begin
                  aw_done   <= 1'b1;
                  aw_addr_q <= bus.AWADDR;
               end
               if (w_fire) begin
                  w_done   <= 1'b1;
                  w_data_q <= bus.WDATA;
                  w_strb_q <= bus.WSTRB;
               end
               bus.AWREADY <= !(aw_done || aw_fire);
               bus.WREADY  <= !(w_done || w_fire);
               if (commit) begin
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
                  bus.AWREADY <= 1'b0;
                  bus.WREADY  <= 1'b0;
                  bus.BVALID  <= 1'b1;
                  bus.BRESP   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                  wr_state    <= W_RESP;
               end
            end
            W_RESP: begin
               if (bus.BREADY) begin
                  bus.BVALID  <= 1'b0;
                  bus.AWREADY <= 1'b1;
                  bus.WREADY  <= 1'b1;
                  wr_state    <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rd_state    <= R_IDLE;
         bus.ARREADY <= 1'b0;
         bus.RVALID  <= 1'b0;
         bus.RRESP   <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               bus.ARREADY <= 1'b1;
               if (ar_fire) begin
                  bus.ARREADY <= 1'b0;
                  bus.RVALID  <= 1'b1;
                  bus.RRESP   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                  rd_state    <= R_DATA;
               end
            end
            R_DATA: begin
               if (bus.RREADY) begin
                  bus.RVALID  <= 1'b0;
                  bus.ARREADY <= 1'b1;
                  rd_state    <= R_IDLE;
               end
            end
         endcase
      end
   end

   axi4_lite_mem_array #(
      .Mem_Depth  (Mem_Depth),
      .Data_Width (Data_Width)
   ) u_mem (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (commit && wr_hit),
      .wr_idx  (wr_off[IDX_W+1:2]),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_en   (ar_fire),
      .rd_hit  (rd_hit),
      .rd_idx  (rd_off[IDX_W+1:2]),
      .rd_data (bus.RDATA)
   );

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed and randomized bench for axi4_lite_slave_mem against a word-array model.
module tb_axi4_lite_slave_mem;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] LIMIT = BASE + 4 * DEPTH;

   logic ACLK;
   logic ARESET;
   axi4_lite_slave_mem_if bus ();

   axi4_lite_slave_mem #(
      .Mem_Depth (DEPTH),
      .Base_Addr (BASE)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int tests = 0;
   int fails = 0;

   logic [31:0] ref_mem [DEPTH];
   bit          ref_written [DEPTH];
   logic [31:0] written_q [$];

   logic [31:0] rd_exp_data;
   logic [1:0]  rd_exp_resp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      tests++;
      fails++;
      $error("FAIL %s handshake timeout", tag);
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a >= BASE) && (a < LIMIT);
   endfunction

   function automatic logic [1:0] ref_write(input logic [31:0] a, input logic [31:0] d,
                                            input logic [3:0] s);
      int idx;
      if (!in_range(a)) return 2'b10;
      idx = int'((a - BASE) >> 2);
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      if (!ref_written[idx]) written_q.push_back(a & 32'hFFFF_FFFC);
      ref_written[idx] = 1'b1;
      return 2'b00;
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input string tag);
      int cyc;
      bit aw_ok, w_ok;
      logic [1:0] exp_resp;
      aw_ok = 0; w_ok = 0; cyc = 0;
      bus.AWADDR = addr;
      bus.AWPROT = 3'($urandom);
      bus.WDATA  = data;
      bus.WSTRB  = strb;
      while (!(aw_ok && w_ok)) begin
         @(negedge ACLK);
         if (cyc > 40) begin
            timeout_fail({tag, ".hs"});
            break;
         end
         if (aw_ok && !w_ok) begin
            check({tag, ".awready_after_aw"}, 32'(bus.AWREADY), 32'd0);
            check({tag, ".wready_pending"},   32'(bus.WREADY),  32'd1);
         end
         if (w_ok && !aw_ok) begin
            check({tag, ".wready_after_w"},   32'(bus.WREADY),  32'd0);
            check({tag, ".awready_pending"},  32'(bus.AWREADY), 32'd1);
         end
         bus.AWVALID = !aw_ok && (cyc >= aw_dly);
         bus.WVALID  = !w_ok && (cyc >= w_dly);
         if (bus.AWVALID && bus.AWREADY) aw_ok = 1;
         if (bus.WVALID && bus.WREADY)   w_ok = 1;
         if (aw_ok && w_ok) check({tag, ".bvalid_early"}, 32'(bus.BVALID), 32'd0);
         cyc++;
      end
      exp_resp = ref_write(addr, data, strb);
      @(negedge ACLK);
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      check({tag, ".bvalid"}, 32'(bus.BVALID), 32'd1);
      check({tag, ".bresp"},  32'(bus.BRESP),  32'(exp_resp));
      if (bus.BREADY) begin
         @(negedge ACLK);
         check({tag, ".bvalid_clr"}, 32'(bus.BVALID),  32'd0);
         check({tag, ".awready_re"}, 32'(bus.AWREADY), 32'd1);
      end
   endtask

   task automatic read_issue(input logic [31:0] addr, input int ar_dly, input string tag);
      int cyc;
      bit ok;
      int idx;
      ok = 0; cyc = 0;
      if (in_range(addr)) begin
         idx = int'((addr - BASE) >> 2);
         rd_exp_data = ref_mem[idx];
         rd_exp_resp = 2'b00;
      end else begin
         rd_exp_data = 32'h0;
         rd_exp_resp = 2'b10;
      end
      bus.ARADDR = addr;
      bus.ARPROT = 3'($urandom);
      bus.RREADY = 1'b0;
      while (!ok) begin
         @(negedge ACLK);
         if (cyc > 40) begin
            timeout_fail({tag, ".arhs"});
            break;
         end
         bus.ARVALID = (cyc >= ar_dly);
         if (bus.ARVALID && bus.ARREADY) begin
            ok = 1;
            check({tag, ".rvalid_early"}, 32'(bus.RVALID), 32'd0);
         end
         cyc++;
      end
      @(negedge ACLK);
      bus.ARVALID = 1'b0;
      check({tag, ".rvalid"}, 32'(bus.RVALID), 32'd1);
      check({tag, ".rdata"},  bus.RDATA,       rd_exp_data);
      check({tag, ".rresp"},  32'(bus.RRESP),  32'(rd_exp_resp));
   endtask

   task automatic read_hold(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge ACLK);
         check({tag, ".hold_rvalid"},  32'(bus.RVALID),  32'd1);
         check({tag, ".hold_rdata"},   bus.RDATA,        rd_exp_data);
         check({tag, ".hold_rresp"},   32'(bus.RRESP),   32'(rd_exp_resp));
         check({tag, ".hold_arready"}, 32'(bus.ARREADY), 32'd0);
      end
   endtask

   task automatic read_finish(input string tag);
      bus.RREADY = 1'b1;
      @(negedge ACLK);
      bus.RREADY = 1'b0;
      check({tag, ".rvalid_clr"}, 32'(bus.RVALID),  32'd0);
      check({tag, ".arready_re"}, 32'(bus.ARREADY), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int stall, input string tag);
      read_issue(addr, ar_dly, tag);
      read_hold(stall, tag);
      read_finish(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d, old;
      logic [3:0]  s;

      ARESET = 1'b1;
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b1;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_written[i] = 1'b0;

      repeat (3) @(negedge ACLK);
      check("rst.awready", 32'(bus.AWREADY), 32'd0);
      check("rst.wready",  32'(bus.WREADY),  32'd0);
      check("rst.arready", 32'(bus.ARREADY), 32'd0);
      check("rst.bvalid",  32'(bus.BVALID),  32'd0);
      check("rst.rvalid",  32'(bus.RVALID),  32'd0);
      check("rst.bresp",   32'(bus.BRESP),   32'd0);
      check("rst.rresp",   32'(bus.RRESP),   32'd0);
      check("rst.rdata",   bus.RDATA,        32'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst.awready_up", 32'(bus.AWREADY), 32'd1);
      check("rst.wready_up",  32'(bus.WREADY),  32'd1);
      check("rst.arready_up", 32'(bus.ARREADY), 32'd1);

      axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, "t1.wr");
      axi_read(32'h10, 0, 0, "t1.rd");

      axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, "t2.pre");
      axi_write(32'h20, 32'h1122_3344, 4'b0101, 0, 0, "t2.wr");
      axi_read(32'h20, 0, 0, "t2.rd");
      check("t2.model", ref_mem[8], 32'hFF22_FF44);

      axi_write(32'h30, 32'hA5A5_A5A5, 4'hF, 0, 3, "t3.wr");
      axi_read(32'h30, 1, 0, "t3.rd");

      axi_write(32'h00, 32'h0BAD_F00D, 4'hF, 1, 0, "t4.pre");
      axi_write(LIMIT, 32'h1234_5678, 4'hF, 0, 0, "t4.wr_oob");
      axi_read(LIMIT, 0, 0, "t4.rd_oob");
      axi_read(32'h00, 0, 0, "t4.rd_word0");
      axi_read(32'hFFFF_FFF0, 0, 1, "t4.rd_high");

      axi_write(32'h24, 32'h5555_AAAA, 4'hF, 0, 0, "t6.pre");
      axi_write(32'h24, 32'hFFFF_FFFF, 4'h0, 0, 0, "t6.nostrb");
      axi_read(32'h24, 0, 0, "t6.rd");

      read_issue(32'h10, 0, "t5.rd");
      read_hold(1, "t5.a");
      axi_write(32'h14, 32'hCAFE_0014, 4'hF, 0, 1, "t5.wr");
      read_hold(2, "t5.b");
      read_finish("t5.rd");
      axi_read(32'h14, 0, 0, "t5.rd14");

      // Same-edge AR handshake and write commit on one word.
      axi_write(32'h40, 32'h0000_0040, 4'hF, 0, 0, "col.pre");
      old = ref_mem[16];
      @(negedge ACLK);
      check("col.awready", 32'(bus.AWREADY), 32'd1);
      check("col.arready", 32'(bus.ARREADY), 32'd1);
      bus.AWADDR = 32'h40; bus.WDATA = 32'h7777_8888; bus.WSTRB = 4'hF;
      bus.ARADDR = 32'h40;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
      @(negedge ACLK);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      void'(ref_write(32'h40, 32'h7777_8888, 4'hF));
      check("col.rvalid", 32'(bus.RVALID), 32'd1);
      check("col.bvalid", 32'(bus.BVALID), 32'd1);
      check("col.rdata_old", bus.RDATA, old);
      bus.RREADY = 1'b1;
      @(negedge ACLK);
      bus.RREADY = 1'b0;
      axi_read(32'h40, 0, 0, "col.rd_new");

      bus.BREADY = 1'b0;
      axi_write(32'h50, 32'h600D_DA7A, 4'hF, 0, 0, "rst2.wr");
      ARESET = 1'b1;
      @(negedge ACLK);
      check("rst2.bvalid",  32'(bus.BVALID),  32'd0);
      check("rst2.awready", 32'(bus.AWREADY), 32'd0);
      check("rst2.wready",  32'(bus.WREADY),  32'd0);
      check("rst2.arready", 32'(bus.ARREADY), 32'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      bus.BREADY = 1'b1;
      @(negedge ACLK);
      check("rst2.awready_up", 32'(bus.AWREADY), 32'd1);
      check("rst2.wready_up",  32'(bus.WREADY),  32'd1);
      check("rst2.arready_up", 32'(bus.ARREADY), 32'd1);
      check("rst2.bvalid_lo",  32'(bus.BVALID),  32'd0);
      axi_read(32'h50, 0, 0, "rst2.rd");
      axi_read(32'h10, 0, 0, "rst2.rd10");

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0 || written_q.size() == 0) begin
            if ($urandom_range(0, 7) == 0) a = LIMIT + 32'($urandom_range(0, 4095));
            else a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom);
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), "rnd.wr");
         end else begin
            a = written_q[$urandom_range(0, written_q.size() - 1)] + 32'($urandom_range(0, 3));
            axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), "rnd.rd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi4_lite_slave_mem.md
Name: axi4_lite_slave_mem

Overview:
AXI4-Lite slave endpoint that sits directly downstream of the bus master and consumes the AXI4-Lite transactions it issues. It terminates all five channels into a word-addressed, byte-strobed memory. Address and data widths come from the shared AXI4-Lite package parameters. It is the DUT memory target for the bus environment.

Parameters:
Addr_Width, 32, address bus width (from axi4_lite_Defs)
Data_Width, 32, data bus width (from axi4_lite_Defs); fixed 32 in this block
Mem_Depth, 1024, number of 32-bit words
Base_Addr, 32'h0000_0000, byte address of word 0

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset; synchronous, active-high
AWADDR  in  Addr_Width  write address
AWPROT  in  3  accepted, ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  Data_Width  write data
WSTRB  in  Data_Width/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  Addr_Width  read address
ARPROT  in  3  accepted, ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  Data_Width  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready

Behaviour:
- Reset, while ARESET=1: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0. Memory contents are not reset. READYs rise on the first edge after ARESET falls.
- Reset mid-transaction: the in-flight transaction is abandoned and any pending VALID drops on the reset edge. No partial write is committed unless the commit edge has already occurred.
- Decode: in range iff Base_Addr <= addr < Base_Addr + 4*Mem_Depth. Word index is (addr-Base_Addr)>>2. addr[1:0] is ignored, so accesses are word-aligned.
- Response codes: OKAY=2'b00 for in range, SLVERR=2'b10 for out of range.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - Commit happens on the edge after both are captured, or on the same edge if both handshake together. At commit, memory bytes with WSTRB[i]=1 are written if in range. BVALID=1 with BRESP registered the same edge. Go to W_RESP.
  - W_RESP: AWREADY=0 and WREADY=0. Hold BVALID/BRESP stable until BVALID&&BREADY, then go to W_IDLE with both READYs 1 on the next cycle.
  - Write latency: BVALID is high 1 cycle after the AW and W handshakes complete.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, capture RDATA from memory (0 if out of range) and RRESP, set RVALID=1, go to R_DATA.
  - R_DATA: ARREADY=0. Hold RDATA/RRESP/RVALID stable until RVALID&&RREADY, then go to R_IDLE.
  - Read latency: RVALID is high 1 cycle after the AR handshake.
- Read and write channels are fully independent and may overlap.
- Read/write collision: an AR handshake and a write commit to the same word on the same edge return the old data (read-before-write).
- WSTRB=0 is a legal no-op write that still returns OKAY.
- BREADY or RREADY held low indefinitely stalls only that channel.

Decomposition:
- Add to axi4_lite_Defs:
  - resp constants RESP_OKAY and RESP_SLVERR;
  - enum wr_state_t {W_IDLE, W_RESP};
  - enum rd_state_t {R_IDLE, R_DATA}.
- Sub-module axi4_lite_mem_array: synchronous RAM with one byte-enable write port and one registered read port, with read-before-write collision behaviour, parameterised by Mem_Depth.

Test Plan:
- Write 0xDEADBEEF to 0x10 with WSTRB=4'hF, AW and W in the same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=00. Read 0x10 -> RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR.
- Write 0x11223344 to 0x20 with WSTRB=4'b0101 over prior 0xFFFFFFFF -> read 0x20 returns 0xFF22FF44.
- AW for 0x30 three cycles before W (0xA5A5A5A5) -> WREADY stays 1, AWREADY drops after capture, single BVALID after W, read returns 0xA5A5A5A5.
- Write and read to Base_Addr+4*Mem_Depth (0x1000) -> BRESP=10 with memory unchanged; RRESP=10 with RDATA=0.
- Hold RREADY=0 for 5 cycles after AR 0x10 -> RVALID, RDATA and RRESP stable and ARREADY=0 throughout. A concurrent write to 0x14 completes meanwhile.
- Assert ARESET while BVALID=1 -> BVALID=0 on the next edge, READYs=0 during reset then 1 after. Previously written data is still readable.
